seq_gen_cmd_driver: RTL
=======================

// Module: seq_gen_cmd_driver
// PURPOSE
//  Upstream stimulus stage for sequence_gen: buffers calculation commands in a FIFO and
//  drives them onto the sequence_gen inputs using the legal protocol (2-cycle load, one-hot
//  mode, stable order/data_in). Captures done/overflow/error/timeout and returns a tagged
//  response. Sits between the testbench command source and sequence_gen, and so feeds
//  seq_gen_chkr.
// PARAMETERS
//  DEPTH         4   command FIFO entries; power of 2, >= 2
//  TIMEOUT_SLACK 4   extra cycles beyond order+2 before a timeout is declared
// PORTS
//  clk          in   1   clock, rising edge
//  reset_n      in   1   asynchronous active-low reset
//  cmd_valid    in   1   command offered
//  cmd_ready    out  1   FIFO can accept; equals (count != DEPTH)
//  cmd_mode     in   1   0 = fibonacci, 1 = triangle
//  cmd_order    in   16  Nth term requested
//  cmd_data     in   64  initial value
//  fibonacci    out  1   to sequence_gen
//  triangle     out  1   to sequence_gen
//  load         out  1   to sequence_gen
//  clear        out  1   to sequence_gen
//  order        out  16  to sequence_gen
//  data_in      out  64  to sequence_gen
//  done         in   1   from sequence_gen
//  data_out     in   64  from sequence_gen
//  overflow     in   1   from sequence_gen
//  error        in   1   from sequence_gen
//  rsp_valid    out  1   response available
//  rsp_ready    in   1   response consumed
//  rsp_data     out  64  captured data_out (0 on timeout)
//  rsp_status   out  2   00 ok, 01 overflow, 10 error, 11 timeout
//  rsp_latency  out  18  cycles from first load cycle to response capture
//  busy         out  1   FSM not in IDLE
// BEHAVIOUR
//  - Reset (async, reset_n = 0): every output 0 immediately; FIFO emptied; FSM in IDLE.
//    Mid-operation reset drops load at once; no response is produced.
//  - All sequence_gen-facing outputs are registered.
//  - FIFO write on cmd_valid & cmd_ready. Pop only in IDLE when non-empty.
//    Push and pop in the same cycle keep count unchanged.
//  - FSM: IDLE -> LOAD1 -> LOAD2 -> WAIT -> RESP -> CLR -> IDLE.
//    - IDLE: pop the head into the command register.
//      load rises on the cycle after the pop; the first load is 2 cycles after the accepting edge.
//    - LOAD1/LOAD2: load=1 with order/data_in from the command register.
//      Exactly one of fibonacci/triangle is high, per cmd_mode.
//    - Outside LOAD1/LOAD2: load, fibonacci, triangle = 0; order and data_in driven 0
//      (never X/Z).
//  - Latency counter (18 b): cleared to 0 in LOAD1, +1 per cycle through WAIT; saturates.
//  - Response capture is sampled in LOAD2 and WAIT.
//    - Priority when several are high: error > overflow > done.
//    - Capture data_out, status and counter, then go to RESP.
//  - Timeout: no capture and counter == order + 2 + TIMEOUT_SLACK.
//    The sum is computed in 18 b, so order = 16'hFFFF cannot wrap.
//    Result: status 11, rsp_data = 0, go to RESP.
//  - RESP: rsp_valid held with stable rsp_* until rsp_ready; leave on the handshake edge.
//  - CLR: clear = 1 for exactly 1 cycle, then IDLE. Next command load is >= 2 cycles after clear.
//  - done/overflow/error asserted in IDLE, RESP or CLR are ignored (no response, no state change).
//  - rsp_* are only meaningful while rsp_valid = 1; they hold their last value otherwise.
// TESTING
//  1. Reset mid-WAIT (reset_n low for 3 cycles) -> load, clear, rsp_valid and busy all 0
//     during reset; FIFO empty; cmd_ready = 1 after release.
//  2. Push fib, order = 5, data = 1; model raises done with data_out = 8 at counter = 7
//     -> rsp_status 00, rsp_data 8, rsp_latency 7; load high exactly 2 cycles;
//     fibonacci = 1 and triangle = 0 during load.
//  3. Push DEPTH + 1 commands back-to-back with rsp_ready = 1 -> cmd_ready low while full;
//     all DEPTH + 1 commands issued in order; one clear pulse per command.
//  4. Same cycle error = 1 and overflow = 1, data_out = 64'hFFFF_FFFF_FFFF_FFFF
//     -> rsp_status 10.
//  5. order = 3, model never responds -> rsp_status 11 at rsp_latency 9; rsp_data 0;
//     then clear pulses once.
//  6. rsp_ready held low for 10 cycles -> rsp_valid and rsp_* stable; no new load issued;
//     rsp_ready = 1 -> CLR then next command.

Source files
------------

// File: rtl/seq_gen_cmd_driver.sv
// Command driver for sequence_gen: FIFO-buffered commands, two-cycle load protocol,
// and a tagged response (ok / overflow / error / timeout) with latency measurement.
module seq_gen_cmd_driver #(
    parameter int DEPTH         = 4,
    parameter int TIMEOUT_SLACK = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_mode,
    input  logic [15:0] cmd_order,
    input  logic [63:0] cmd_data,
    output logic        fibonacci,
    output logic        triangle,
    output logic        load,
    output logic        clear,
    output logic [15:0] order,
    output logic [63:0] data_in,
    input  logic        done,
    input  logic [63:0] data_out,
    input  logic        overflow,
    input  logic        error,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic [1:0]  rsp_status,
    output logic [17:0] rsp_latency,
    output logic        busy
);
    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [17:0] TMO_EXTRA = 18'(2 + TIMEOUT_SLACK);

    typedef enum logic [2:0] {IDLE, LOAD1, LOAD2, WAIT, RESP, CLR} state_t;

    state_t        state_q, state_d;
    logic [80:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          run_q;
    logic          push, pop, drive;

    logic          cmd_mode_q;
    logic [15:0]   cmd_order_q;
    logic [63:0]   cmd_data_q;
    logic [17:0]   cnt_q, cnt_d;
    logic [17:0]   tmo_limit;
    logic          cap, tmo;
    logic [1:0]    cap_status;

    logic          fib_q, tri_q, load_q, clear_q, rsp_valid_q, busy_q;
    logic [15:0]   order_q;
    logic [63:0]   data_in_q, rsp_data_q;
    logic [1:0]    rsp_status_q;
    logic [17:0]   rsp_latency_q;

    // run_q keeps cmd_ready low while reset is asserted, so every output reads 0 in reset.
    assign cmd_ready = run_q && (count_q != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == IDLE) && (count_q != '0);
    assign drive     = (state_q == LOAD1) || (state_q == LOAD2);
    // 18-bit sum: order = 16'hFFFF cannot wrap the timeout threshold.
    assign tmo_limit = {2'b00, cmd_order_q} + TMO_EXTRA;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_mode, cmd_order, cmd_data};
        if (pop) {cmd_mode_q, cmd_order_q, cmd_data_q} <= mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            run_q    <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cap        = 1'b0;
        tmo        = 1'b0;
        cap_status = 2'b00;
        if (error)         cap_status = 2'b10;
        else if (overflow) cap_status = 2'b01;
        case (state_q)
            IDLE:  if (pop) state_d = LOAD1;
            LOAD1: begin
                state_d = LOAD2;
                cnt_d   = '0;
            end
            LOAD2, WAIT: begin
                if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                if (error || overflow || done) begin
                    cap     = 1'b1;
                    state_d = RESP;
                end else if (cnt_q == tmo_limit) begin
                    tmo     = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP:    if (rsp_ready) state_d = CLR;
            CLR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Load-side outputs are registered from the state, so load appears one cycle after LOAD1 starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            load_q        <= 1'b0;
            fib_q         <= 1'b0;
            tri_q         <= 1'b0;
            order_q       <= '0;
            data_in_q     <= '0;
            clear_q       <= 1'b0;
            busy_q        <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_status_q  <= '0;
            rsp_latency_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            load_q      <= drive;
            fib_q       <= drive && !cmd_mode_q;
            tri_q       <= drive && cmd_mode_q;
            order_q     <= drive ? cmd_order_q : '0;
            data_in_q   <= drive ? cmd_data_q : '0;
            clear_q     <= (state_d == CLR);
            busy_q      <= (state_d != IDLE);
            rsp_valid_q <= (state_d == RESP);
            if (cap) begin
                rsp_data_q    <= data_out;
                rsp_status_q  <= cap_status;
                rsp_latency_q <= cnt_q;
            end else if (tmo) begin
                rsp_data_q    <= '0;
                rsp_status_q  <= 2'b11;
                rsp_latency_q <= cnt_q;
            end
        end
    end

    assign fibonacci   = fib_q;
    assign triangle    = tri_q;
    assign load        = load_q;
    assign clear       = clear_q;
    assign order       = order_q;
    assign data_in     = data_in_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_status  = rsp_status_q;
    assign rsp_latency = rsp_latency_q;
    assign busy        = busy_q;
endmodule
